updown_sweep_ctrl: RTL and testbench
====================================

// Module: updown_sweep_ctrl
// PURPOSE
//  Upstream sequencer for a TTL74x269-style up/down counter. It drives the counter's PE_n, P,
//  U_D, CEP_n and CET_n pins and watches its TC_n pin. It loads a start value, then steps the
//  counter at a programmable rate. Three modes: stop at terminal count, bounce between
//  terminals (triangle sweep), or free-run with wrap-around. Reports busy/done/reversal count.
// PARAMETERS
//  DATA_WIDTH  8  counter width; width of P and start_val
//  RATE_WIDTH  8  width of step-rate divider
//  SWP_WIDTH   8  width of sweeps / reversals
// PORTS
//  clk        in   1           system clock; single clock domain
//  rst        in   1           synchronous reset, active-high
//  start      in   1           begin sequence (sampled in IDLE only)
//  abort      in   1           terminate sequence, no done pulse
//  mode       in   2           0 ONESHOT, 1 TRIANGLE, 2 WRAP, 3 reserved (treated as ONESHOT)
//  dir_init   in   1           initial direction, 1 = up
//  start_val  in   DATA_WIDTH  value loaded into counter
//  rate       in   RATE_WIDTH  one count step every rate+1 clocks
//  sweeps     in   SWP_WIDTH   TRIANGLE terminal hits before done; 0 = endless
//  TC_n       in   1           counter terminal count, active-low (combinational from counter)
//  PE_n       out  1           counter parallel load, active-low
//  P          out  DATA_WIDTH  counter parallel data
//  U_D        out  1           counter direction, 1 = up
//  CEP_n      out  1           counter count enable, active-low
//  CET_n      out  1           same value as CEP_n
//  busy       out  1           high in LOAD, COUNT and REVERSE
//  done       out  1           one-cycle pulse on normal completion
//  reversals  out  SWP_WIDTH   TRIANGLE terminal hits in the current sequence
// BEHAVIOUR
//  - Reset values: state IDLE, PE_n=1, CEP_n=CET_n=1, U_D=1, P=0, busy=0, done=0, reversals=0.
//  - Registered config: start in IDLE captures mode, rate and sweeps; P<=start_val; U_D<=dir_init;
//    reversals<=0; next state LOAD. The inputs are not re-sampled until the next IDLE.
//  - LOAD (1 cycle): PE_n=0, so the counter loads P on the exiting edge. div_cnt<=rate. Next: COUNT.
//  - COUNT: tick = (div_cnt==0). On tick, div_cnt<=rate; otherwise div_cnt decrements.
//    CEP_n = CET_n = !(COUNT && tick && (TC_n || mode==WRAP)).
//    This is the only combinational input-to-output path (TC_n -> CEP_n/CET_n).
//  - Terminal (COUNT && TC_n==0), checked every COUNT cycle, independent of tick:
//    ONESHOT -> DONE. The counter holds its terminal value.
//    TRIANGLE with sweeps!=0 and reversals+1==sweeps -> DONE; reversals increments.
//    TRIANGLE otherwise -> REVERSE; U_D toggles and reversals increments (wraps at 2^SWP_WIDTH).
//    WRAP -> no action. The counter steps through the terminal and wraps (FF->00 or 00->FF).
//  - REVERSE (1 cycle): enables stay high so TC_n can settle with the new U_D. div_cnt<=rate.
//    Next: COUNT.
//  - DONE (1 cycle): done=1, busy=0. Next: IDLE.
//  - Priority: rst > abort > terminal/tick > start.
//    abort in LOAD, COUNT or REVERSE -> IDLE on the next edge, enables high, no done pulse.
//    P, U_D and reversals keep their values.
//  - start while busy or in DONE is ignored. start and abort in the same IDLE cycle -> stay IDLE.
//  - start_val already terminal in dir_init: terminal is detected in the first COUNT cycle,
//    so zero steps are taken.
//  - rst mid-sequence: all state returns to reset values on that edge. The counter itself is
//    not reset by this block.
// STRUCTURE
//  - Shared package (sweep_pkg): MODE_ONESHOT/TRIANGLE/WRAP localparams and the state
//    encodings IDLE, LOAD, COUNT, REVERSE, DONE.
//  - Sub-module sweep_tick_gen: rate divider. Inputs clk, rst, reload, rate; output tick.
//  - The FSM and output decode stay in this module.
// TESTING (bench pairs this block with a TTL74x269 instance, DATA_WIDTH=8)
//  1. ONESHOT, start_val=FC, dir_init=1, rate=0 -> PE_n low 1 cycle, CEP_n low 3 cycles,
//     Q=FD,FE,FF, then one done pulse; Q holds FF.
//  2. TRIANGLE, sweeps=2, start_val=FE, up, rate=0 -> Q reaches FF, reversals=1, U_D=0,
//     255 down-steps to 00, then done with reversals=2 and Q=00.
//  3. ONESHOT, rate=3 -> CEP_n low exactly 1 cycle in every 4 while counting;
//     first enable in the 4th COUNT cycle.
//  4. WRAP, start_val=FF, up -> Q=00,01,... across the terminal; abort -> CEP_n high next
//     cycle, busy=0, no done pulse.
//  5. ONESHOT, start_val=00, dir_init=0 -> no CEP_n low cycles; done 2 cycles after the
//     LOAD cycle.
//  6. rst asserted mid-COUNT, and start pulsed while busy -> reset values on the next edge;
//     the start pulse has no effect.

Source files
------------

// File: rtl/sweep_pkg.sv
// Shared definitions for the up/down counter sweep sequencer.
// Mode codes and FSM state encoding.
package sweep_pkg;

    localparam logic [1:0] MODE_ONESHOT  = 2'd0;
    localparam logic [1:0] MODE_TRIANGLE = 2'd1;
    localparam logic [1:0] MODE_WRAP     = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        COUNT,
        REVERSE,
        DONE
    } state_e;

endpackage

// File: rtl/sweep_tick_gen.sv
// Step-rate divider: tick is high one cycle in every rate+1.
// reload restarts the period from rate.
module sweep_tick_gen #(
    parameter int RATE_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  reload,
    input  logic [RATE_WIDTH-1:0] rate,
    output logic                  tick
);

    logic [RATE_WIDTH-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q - 1'b1;
        if (reload || tick) begin
            cnt_d = rate;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/updown_sweep_ctrl.sv
// Sequencer for a 74x269-style up/down counter: load, then step
// in one-shot, triangle or wrap mode at a programmable rate.
module updown_sweep_ctrl
    import sweep_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int RATE_WIDTH = 8,
    parameter int SWP_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [1:0]            mode,
    input  logic                  dir_init,
    input  logic [DATA_WIDTH-1:0] start_val,
    input  logic [RATE_WIDTH-1:0] rate,
    input  logic [SWP_WIDTH-1:0]  sweeps,
    input  logic                  TC_n,
    output logic                  PE_n,
    output logic [DATA_WIDTH-1:0] P,
    output logic                  U_D,
    output logic                  CEP_n,
    output logic                  CET_n,
    output logic                  busy,
    output logic                  done,
    output logic [SWP_WIDTH-1:0]  reversals
);

    state_e                state_q, state_d;
    logic [1:0]            mode_q, mode_d;
    logic [RATE_WIDTH-1:0] rate_q, rate_d;
    logic [SWP_WIDTH-1:0]  sweeps_q, sweeps_d;
    logic [DATA_WIDTH-1:0] p_q, p_d;
    logic                  ud_q, ud_d;
    logic [SWP_WIDTH-1:0]  rev_q, rev_d;
    logic                  tick;
    logic                  step_en;

    sweep_tick_gen #(
        .RATE_WIDTH(RATE_WIDTH)
    ) u_tick (
        .clk   (clk),
        .rst   (rst),
        .reload(state_q == LOAD || state_q == REVERSE),
        .rate  (rate_q),
        .tick  (tick)
    );

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        rate_d   = rate_q;
        sweeps_d = sweeps_q;
        p_d      = p_q;
        ud_d     = ud_q;
        rev_d    = rev_q;
        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    mode_d   = (mode == MODE_TRIANGLE || mode == MODE_WRAP)
                               ? mode : MODE_ONESHOT;
                    rate_d   = rate;
                    sweeps_d = sweeps;
                    p_d      = start_val;
                    ud_d     = dir_init;
                    rev_d    = '0;
                    state_d  = LOAD;
                end
            end
            LOAD:    state_d = abort ? IDLE : COUNT;
            REVERSE: state_d = abort ? IDLE : COUNT;
            COUNT: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (!TC_n && mode_q != MODE_WRAP) begin
                    if (mode_q == MODE_TRIANGLE) begin
                        rev_d = rev_q + 1'b1;
                        if (sweeps_q != '0 && rev_d == sweeps_q) begin
                            state_d = DONE;
                        end else begin
                            ud_d    = !ud_q;
                            state_d = REVERSE;
                        end
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            mode_q   <= MODE_ONESHOT;
            rate_q   <= '0;
            sweeps_q <= '0;
            p_q      <= '0;
            ud_q     <= 1'b1;
            rev_q    <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            rate_q   <= rate_d;
            sweeps_q <= sweeps_d;
            p_q      <= p_d;
            ud_q     <= ud_d;
            rev_q    <= rev_d;
        end
    end

    // Wrap mode steps straight through the terminal value.
    assign step_en = (state_q == COUNT) && tick
                     && (TC_n || mode_q == MODE_WRAP);

    assign PE_n      = (state_q != LOAD);
    assign CEP_n     = !step_en;
    assign CET_n     = !step_en;
    assign busy      = (state_q == LOAD) || (state_q == COUNT)
                       || (state_q == REVERSE);
    assign done      = (state_q == DONE);
    assign P         = p_q;
    assign U_D       = ud_q;
    assign reversals = rev_q;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Bench: sweep controller driving a behavioural 74x269 counter,
// checked cycle by cycle against a step-level reference model.
module tb_updown_sweep_ctrl;

    localparam int MAXC = 4000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [1:0] mode = 2'd0;
    logic       dir_init = 1'b1;
    logic [7:0] start_val = 8'h00;
    logic [7:0] rate = 8'h00;
    logic [7:0] sweeps = 8'h00;
    logic       TC_n;
    logic       PE_n;
    logic [7:0] P;
    logic       U_D;
    logic       CEP_n;
    logic       CET_n;
    logic       busy;
    logic       done;
    logic [7:0] reversals;

    logic [7:0] q = 8'h5A;

    int    n_cmp = 0;
    int    n_bad = 0;
    string cur_run = "reset";
    int    cur_cyc = 0;

    logic       e_pen [MAXC];
    logic       e_cen [MAXC];
    logic       e_busy[MAXC];
    logic       e_done[MAXC];
    logic       e_ud  [MAXC];
    logic [7:0] e_q   [MAXC];
    logic [7:0] e_rev [MAXC];
    int         ncyc;
    int         ndone;

    always #5 clk = ~clk;

    updown_sweep_ctrl #(
        .DATA_WIDTH(8),
        .RATE_WIDTH(8),
        .SWP_WIDTH (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .mode     (mode),
        .dir_init (dir_init),
        .start_val(start_val),
        .rate     (rate),
        .sweeps   (sweeps),
        .TC_n     (TC_n),
        .PE_n     (PE_n),
        .P        (P),
        .U_D      (U_D),
        .CEP_n    (CEP_n),
        .CET_n    (CET_n),
        .busy     (busy),
        .done     (done),
        .reversals(reversals)
    );

    // Behavioural 74x269: sync load, count when both enables low.
    assign TC_n = !(U_D ? (q == 8'hFF) : (q == 8'h00));

    always @(posedge clk) begin
        if (!PE_n) q <= P;
        else if (!CEP_n && !CET_n) q <= U_D ? q + 8'd1 : q - 8'd1;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s [%s cyc %0d] got %0h want %0h",
                     tag, cur_run, cur_cyc, got, exp);
        end
    endtask

    // Step-level reference: cycle 0 is the load cycle; afterwards the
    // counter value, direction and hit count are tracked per cycle.
    task automatic model(input int md, input int dir, input int sv,
                         input int rt, input int sw, input int ab);
        int v, k, r, ph;
        bit d, live, hit;
        v = sv; k = 0; r = 0; d = dir[0]; ph = 1;
        live = (ab != 0); ndone = 0; ncyc = MAXC;
        e_pen[0] = 0; e_cen[0] = 1; e_busy[0] = 1; e_done[0] = 0;
        e_ud[0] = d; e_rev[0] = 0; e_q[0] = 0;
        for (int c = 1; c < MAXC; c++) begin
            e_q[c] = 8'(v); e_ud[c] = d; e_rev[c] = 8'(r);
            e_pen[c] = 1; e_cen[c] = 1; e_busy[c] = 0; e_done[c] = 0;
            if (!live) begin
                if (ncyc == MAXC) ncyc = (c + 2 < MAXC) ? c + 2 : MAXC;
                continue;
            end
            ndone = c;
            if (ph == 3) begin
                e_done[c] = 1;
                live = 0;
                continue;
            end
            e_busy[c] = 1;
            if (ph == 2) begin
                ph = 1;
                k = 0;
            end else begin
                hit = (md != 2) && (d ? (v == 255) : (v == 0));
                if (hit && c != ab) begin
                    if (md == 1) begin
                        r = (r + 1) % 256;
                        if (sw != 0 && r == sw) ph = 3;
                        else begin d = !d; ph = 2; end
                    end else begin
                        ph = 3;
                    end
                end else if (!hit) begin
                    if (k == rt) begin
                        e_cen[c] = 0;
                        v = d ? (v + 1) % 256 : (v + 255) % 256;
                        k = 0;
                    end else begin
                        k++;
                    end
                end
            end
            if (c == ab) live = 0;
        end
    endtask

    task automatic run(input string name, input int md, input int dir,
                       input int sv, input int rt, input int sw,
                       input int ab, input int st);
        model(md, dir, sv, rt, sw, ab);
        cur_run = name;
        @(negedge clk);
        mode = 2'(md); dir_init = dir[0]; start_val = 8'(sv);
        rate = 8'(rt); sweeps = 8'(sw); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("p_load", 32'(P), 32'(sv));
        for (int c = 0; c < ncyc; c++) begin
            if (c > 0) @(negedge clk);
            cur_cyc = c;
            check("pe_n", 32'(PE_n), 32'(e_pen[c]));
            check("cep_n", 32'(CEP_n), 32'(e_cen[c]));
            check("cet_n", 32'(CET_n), 32'(e_cen[c]));
            check("busy", 32'(busy), 32'(e_busy[c]));
            check("done", 32'(done), 32'(e_done[c]));
            check("u_d", 32'(U_D), 32'(e_ud[c]));
            check("revs", 32'(reversals), 32'(e_rev[c]));
            if (c > 0) check("q", 32'(q), 32'(e_q[c]));
            start = (c == st);
            abort = (c == ab);
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic check_reset_vals(input string name);
        cur_run = name;
        check("rst_pe_n", 32'(PE_n), 32'd1);
        check("rst_cep_n", 32'(CEP_n), 32'd1);
        check("rst_cet_n", 32'(CET_n), 32'd1);
        check("rst_u_d", 32'(U_D), 32'd1);
        check("rst_p", 32'(P), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_revs", 32'(reversals), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog [%s] bench did not finish", cur_run);
        $fatal(1, "watchdog");
    end

    initial begin
        int md, dir, sv, rt, sw, ab, st;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_vals("reset");

        run("oneshot_fc", 0, 1, 'hFC, 0, 0, -1, -1);
        run("tri_fe", 1, 1, 'hFE, 0, 2, -1, -1);
        run("rate3", 0, 1, 'hF0, 3, 0, -1, -1);
        run("wrap_ff", 2, 1, 'hFF, 1, 0, 40, -1);
        run("zero_steps", 0, 0, 'h00, 0, 0, -1, -1);
        run("mode3", 3, 0, 'h03, 1, 0, -1, 2);
        run("abort_load", 1, 1, 'h10, 0, 1, 0, -1);

        // start and abort together in idle keep the block idle
        cur_run = "start_abort";
        @(negedge clk);
        start_val = 8'h77; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("sa_busy", 32'(busy), 32'd0);
        check("sa_pe_n", 32'(PE_n), 32'd1);
        check("sa_p", 32'(P), 32'h10);

        // reset mid-count with a concurrent start pulse
        cur_run = "rst_mid";
        mode = 2'd0; dir_init = 1'b0; start_val = 8'h80;
        rate = 8'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_busy", 32'(busy), 32'd1);
        start = 1'b1; rst = 1'b1;
        @(negedge clk);
        start = 1'b0; rst = 1'b0;
        check_reset_vals("rst_mid");
        @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 25; i++) begin
            md  = $urandom_range(0, 3);
            dir = $urandom_range(0, 1);
            sv  = $urandom_range(0, 1) ? $urandom_range(0, 12)
                                       : 255 - $urandom_range(0, 12);
            if (md == 0 || md == 3) sv = $urandom_range(0, 255);
            rt  = (md == 1) ? $urandom_range(0, 1) : $urandom_range(0, 3);
            sw  = $urandom_range(0, 3);
            ab  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 300) : -1;
            if (md == 2 || (md == 1 && sw == 0)) ab = $urandom_range(1, 600);
            model(md, dir, sv, rt, sw, ab);
            st = ($urandom_range(0, 1) != 0) ? $urandom_range(1, ndone) : -1;
            run($sformatf("rand%0d", i), md, dir, sv, rt, sw, ab, st);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
